// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Latency: n/a (types and defaults only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  // Controller state: zero-fill sweep, then normal arbitration.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage : regfile_pkg

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin grant with a 1-bit "last granted" pointer.
// Latency: grant is combinational; the pointer updates on the edge after a grant.
// Backpressure: grants only while en=1; ungranted requesters simply see gnt=0.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset (pointer resets to 1)
//   en           arbitration enabled this cycle
//   req[1:0]     requester valids
//   gnt[1:0]     one-hot grant (or zero)
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic rr_last_q;
  logic rr_last_d;

  // With both requesting, the one that did not win last time goes next.
  always_comb begin
    gnt       = 2'b00;
    rr_last_d = rr_last_q;
    if (en) begin
      if (req[0] && (!req[1] || rr_last_q)) begin
        gnt[0] = 1'b1;
      end else if (req[1]) begin
        gnt[1] = 1'b1;
      end
    end
    // Every grant is an accepted transfer, since ready is the grant itself.
    if (gnt[0]) begin
      rr_last_d = 1'b0;
    end else if (gnt[1]) begin
      rr_last_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_q <= 1'b1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

endmodule : rr_arb2

// File: rtl/regfile_wb_arbiter.sv
// Owns the register-file write port: zero-fill sweep after reset, then
//   round-robin arbitration between the EX result (req0) and load/multicycle result (req1).
// Latency: a transfer accepted in cycle N drives rf_wen/waddr/wdata in cycle N+1.
// Backpressure: reqN_ready is the combinational grant; no buffering, one write per cycle.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   reqN_valid/addr/data, reqN_ready  writeback requesters (N = 0, 1)
//   rf_wen/rf_waddr/rf_wdata          registered register-file write port
//   init_done                         sweep finished, requesters may be granted
//   stall_cnt                         saturating count of RUN cycles with a waiting requester
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int NREG    = 2 ** ADDR_W,
  parameter int INIT_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              init_done,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(NREG - 1);

  state_e            state_q,     state_d;
  logic [ADDR_W-1:0] ptr_q,       ptr_d;
  logic              rf_wen_q,    rf_wen_d;
  logic [ADDR_W-1:0] rf_waddr_q,  rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q,  rf_wdata_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [1:0] gnt;
  logic       stalled;

  rr_arb2 u_rr_arb2 (
    .clk (clk),
    .rst (rst),
    .en  (state_q == ST_RUN),
    .req ({req1_valid, req0_valid}),
    .gnt (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  // A valid requester that is not granted while arbitrating; INIT waits are not counted.
  assign stalled = (state_q == ST_RUN) &&
                   ((req0_valid && !gnt[0]) || (req1_valid && !gnt[1]));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rf_wen_d    = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      ST_INIT: begin
        if (INIT_EN != 0) begin
          // The sweep deliberately writes r0 too, unlike requester traffic.
          rf_wen_d   = 1'b1;
          rf_waddr_d = ptr_q;
          rf_wdata_d = '0;
          if (ptr_q == PTR_LAST) begin
            state_d = ST_RUN;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // An accepted write to r0 consumes the grant but never reaches the array.
        if (gnt[0]) begin
          rf_wen_d   = (req0_addr != '0);
          rf_waddr_d = req0_addr;
          rf_wdata_d = req0_data;
        end else if (gnt[1]) begin
          rf_wen_d   = (req1_addr != '0);
          rf_waddr_d = req1_addr;
          rf_wdata_d = req1_data;
        end
        if (stalled && !(&stall_cnt_q)) begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      ptr_q       <= '0;
      rf_wen_q    <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rf_wen_q    <= rf_wen_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign rf_wen    = rf_wen_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign init_done = (state_q == ST_RUN);
  assign stall_cnt = stall_cnt_q;

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (CNT_W=4 build so saturation is reachable).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: requesters hold valid/addr/data until they see ready.
module tb_regfile_wb_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req1_valid;
  logic [ADDR_W-1:0] req0_addr,  req1_addr;
  logic [DATA_W-1:0] req0_data,  req1_data;
  logic              req0_ready, req1_ready;
  logic              rf_wen;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              init_done;
  logic [CNT_W-1:0]  stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  regfile_wb_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .NREG    (32),
    .INIT_EN (1),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .init_done  (init_done),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst        = 1'b1;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;

    // 1. one reset cycle, then the zero-fill sweep
    tick();
    rst = 1'b0;
    check("reset_wen",   32'(rf_wen),    32'd0);
    check("reset_waddr", 32'(rf_waddr),  32'd0);
    check("reset_wdata", rf_wdata,       32'd0);
    check("reset_done",  32'(init_done), 32'd0);
    check("reset_stall", 32'(stall_cnt), 32'd0);
    for (int i = 0; i < 32; i++) begin
      tick();
      check("sweep_wen",   32'(rf_wen),    32'd1);
      check("sweep_waddr", 32'(rf_waddr),  32'(i));
      check("sweep_wdata", rf_wdata,       32'd0);
      check("sweep_rdy",   32'({req0_ready, req1_ready}), 32'd0);
      check("sweep_done",  32'(init_done), (i == 31) ? 32'd1 : 32'd0);
    end

    // 3. both valid from rr_last=1: grants alternate 0,1,0,1
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'hAAAA_0001;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'hBBBB_0002;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_rdy0", 32'(req0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_rdy1", 32'(req1_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      check("rr_wen",   32'(rf_wen),   32'd1);
      check("rr_waddr", 32'(rf_waddr), (k % 2 == 0) ? 32'd1 : 32'd2);
      check("rr_wdata", rf_wdata,      (k % 2 == 0) ? 32'hAAAA_0001 : 32'hBBBB_0002);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("rr_stall", 32'(stall_cnt), 32'd4);

    // 2. single requester, accepted same cycle, written next cycle
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEAD_BEEF;
    #1;
    check("single_rdy0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    check("single_wen",   32'(rf_wen),   32'd1);
    check("single_waddr", 32'(rf_waddr), 32'd5);
    check("single_wdata", rf_wdata,      32'hDEAD_BEEF);
    tick();
    check("idle_wen",   32'(rf_wen),   32'd0);
    check("idle_waddr", 32'(rf_waddr), 32'd5);
    check("idle_wdata", rf_wdata,      32'hDEAD_BEEF);

    // 4. write to r0 is accepted but suppressed
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1234_5678;
    #1;
    check("r0_rdy1", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    check("r0_wen",   32'(rf_wen),    32'd0);
    check("r0_stall", 32'(stall_cnt), 32'd4);

    // reset during RUN with a transfer in flight: write dropped
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h0000_0077;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rrst_wen",   32'(rf_wen),    32'd0);
    check("rrst_done",  32'(init_done), 32'd0);
    check("rrst_stall", 32'(stall_cnt), 32'd0);

    // 5. reset again when the sweep pointer reaches 17; req0 waits uncounted
    for (int i = 0; i < 17; i++) begin
      tick();
      check("part_waddr", 32'(rf_waddr),   32'(i));
      check("part_rdy0",  32'(req0_ready), 32'd0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_wen",  32'(rf_wen),    32'd0);
    check("mrst_done", 32'(init_done), 32'd0);
    for (int i = 0; i < 32; i++) begin
      tick();
      check("resweep_wen",   32'(rf_wen),     32'd1);
      check("resweep_waddr", 32'(rf_waddr),   32'(i));
      check("resweep_rdy0",  32'(req0_ready), (i == 31) ? 32'd1 : 32'd0);
      check("resweep_done",  32'(init_done),  (i == 31) ? 32'd1 : 32'd0);
      check("resweep_stall", 32'(stall_cnt),  32'd0);
    end
    tick();
    req0_valid = 1'b0;
    check("wait_wen",   32'(rf_wen),   32'd1);
    check("wait_waddr", 32'(rf_waddr), 32'd7);
    check("wait_wdata", rf_wdata,      32'h0000_0077);

    // 6. continuous contention: stall_cnt saturates at 15
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h3333_3333;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h4444_4444;
    for (int k = 0; k < (2 ** CNT_W) + 5; k++) begin
      tick();
      check("sat_stall", 32'(stall_cnt), (k + 1 < 15) ? 32'(k + 1) : 32'd15);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_regfile_wb_arbiter
